// File: rtl/nn_parameters.sv
// Shared NN dimensioning: input vector length and element type seen by top_nn.
package nn_parameters;

    localparam int IN_SIZE_1 = 13;

    typedef logic signed [11:0] feat_t;

endpackage

// File: rtl/nn_feat_conv.sv
// Combinational feature-beat to NN-element conversion.
// NN_LOADER_SAT_EN defined: clamp to the OUT_W signed range; otherwise keep the low OUT_W bits.
module nn_feat_conv #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

`ifdef NN_LOADER_SAT_EN
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    // ~MAX_V is the most negative OUT_W value, sign-extended to IN_W bits
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    // clamp to the representable element range
    always_comb begin
        if (din > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end else begin
            dout = din[OUT_W-1:0];
        end
    end
`else
    // plain two's-complement truncation
    always_comb begin
        dout = din[OUT_W-1:0];
    end
`endif

endmodule

// File: rtl/nn_input_loader.sv
// Collects a framed serial feature stream into a fill bank and commits it whole to the
// NN input vector, which is then held for HOLD_CYCLES before another commit may occur.
module nn_input_loader
    import nn_parameters::*;
#(
    parameter int IN_SIZE     = IN_SIZE_1,
    parameter int IN_W        = 16,
    parameter int OUT_W       = 12,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic signed [IN_W-1:0]          s_data,
    input  logic                            s_last,
    output logic [IN_SIZE-1:0][OUT_W-1:0]   vec_out,
    output logic                            vec_valid,
    output logic                            hold_busy,
    output logic                            frame_err
);

    localparam int IDX_W = $clog2(IN_SIZE);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(IN_SIZE - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        FULL   = 2'd1,
        RESYNC = 2'd2
    } fill_state_t;

    fill_state_t              state_r, state_s;
    logic [IDX_W-1:0]         idx_r, idx_s;
    logic [CNT_W-1:0]         hold_cnt_r, hold_cnt_s;
    logic [OUT_W-1:0]         fill_r [IN_SIZE];
    logic signed [OUT_W-1:0]  conv_s;
    logic                     hs_s;
    logic                     wr_en_s;
    logic                     err_s;
    logic                     commit_s;

    nn_feat_conv #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_conv (
        .din  (s_data),
        .dout (conv_s)
    );

    // next-state, fill index, framing checks and hold counter
    always_comb begin
        hs_s       = s_valid & s_ready;
        state_s    = state_r;
        idx_s      = idx_r;
        wr_en_s    = 1'b0;
        err_s      = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            FILL: begin
                if (hs_s) begin
                    wr_en_s = 1'b1;
                    if (s_last) begin
                        idx_s = '0;
                        if (idx_r == LAST_IDX) begin
                            state_s = FULL;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else if (idx_r == LAST_IDX) begin
                        // overlong frame: drop the rest up to its s_last
                        idx_s   = '0;
                        err_s   = 1'b1;
                        state_s = RESYNC;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            RESYNC: begin
                if (hs_s && s_last) begin
                    state_s = FILL;
                end else begin
                    state_s = RESYNC;
                end
            end
            FULL: begin
                if (hold_cnt_r == '0) begin
                    commit_s = 1'b1;
                    state_s  = FILL;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = FILL;
                idx_s   = '0;
            end
        endcase

        if (commit_s) begin
            hold_cnt_s = HOLD_LOAD;
        end else if (hold_cnt_r != '0) begin
            hold_cnt_s = hold_cnt_r - CNT_W'(1);
        end else begin
            hold_cnt_s = hold_cnt_r;
        end
    end

    // state, counters and registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= FILL;
            idx_r      <= '0;
            hold_cnt_r <= '0;
            s_ready    <= 1'b0;
            vec_valid  <= 1'b0;
            hold_busy  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            hold_cnt_r <= hold_cnt_s;
            s_ready    <= (state_s != FULL);
            vec_valid  <= commit_s;
            hold_busy  <= (hold_cnt_s != '0);
            frame_err  <= err_s;
        end
    end

    // fill bank and output bank; the output bank only moves as a whole on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                fill_r[i] <= '0;
            end
            vec_out <= '0;
        end else begin
            if (wr_en_s) begin
                fill_r[idx_r] <= conv_s;
            end
            if (commit_s) begin
                for (int i = 0; i < IN_SIZE; i++) begin
                    vec_out[i] <= fill_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_nn_input_loader.sv
// Scoreboard bench for nn_input_loader: expected vectors are queued when a frame is sent
// and compared when vec_valid pulses; hold_busy and vec_out stability are tracked every cycle.
module tb_nn_input_loader;
    import nn_parameters::*;

    localparam int N    = 13;
    localparam int HOLD = 8;

    typedef logic [N-1:0][11:0] vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [15:0]   s_data;
    logic                 s_last;
    vec_t                 vec_out;
    logic                 vec_valid;
    logic                 hold_busy;
    logic                 frame_err;

    int   total = 0;
    int   bad   = 0;
    vec_t exp_q[$];
    vec_t held;
    int   hb_left = 0;
    int   vv_cnt  = 0;
    int   err_cnt = 0;
    int   fr[N];

    nn_input_loader u_dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .hold_busy (hold_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] conv(input int v);
`ifdef NN_LOADER_SAT_EN
        if (v > 2047) return 12'h7FF;
        else if (v < -2048) return 12'h800;
        else return v[11:0];
`else
        return v[11:0];
`endif
    endfunction

    // per-cycle monitor: scoreboard pop, output stability, hold_busy model
    always @(negedge clk) begin
        vec_t e;
        if (rst) begin
            check("rst_outs", {s_ready, vec_valid, hold_busy, frame_err, vec_out}, '0);
            held    = '0;
            hb_left = 0;
            exp_q.delete();
        end else begin
            if (vec_valid) begin
                vv_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_vv", 1'b1, 1'b0);
                    held = vec_out;
                end else begin
                    e = exp_q.pop_front();
                    check("vec_out", vec_out, e);
                    held = e;
                end
                hb_left = HOLD;
            end else begin
                check("vec_stable", vec_out, held);
            end
            check("hold_busy", hold_busy, hb_left != 0);
            if (hb_left > 0) hb_left--;
            if (frame_err) err_cnt++;
        end
    end

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic beat(input int d, input bit last);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = 16'(d);
        s_last  = last;
        while (!s_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!s_ready) begin
            check("ready_timeout", 1'b0, 1'b1);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame();
        vec_t e;
        for (int i = 0; i < N; i++) e[i] = conv(fr[i]);
        exp_q.push_back(e);
        for (int i = 0; i < N; i++) beat(fr[i], i == N - 1);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int e0;
        int v0;
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1) ramp frame, commit latency and hold
        for (int i = 0; i < N; i++) fr[i] = i;
        send_frame();
        idle();
        @(negedge clk);
        check("vv_early", vec_valid, 1'b0);
        check("ready_in_full", s_ready, 1'b0);
        @(negedge clk);
        check("vv_latency", vec_valid, 1'b1);
        check("ready_back", s_ready, 1'b1);
        check("ramp_elem5", vec_out[5], 12'd5);
        check("ramp_elem12", vec_out[12], 12'd12);
        repeat (12) @(posedge clk);
        #1;

        // 2) back-to-back frames with s_valid held high
        for (int i = 0; i < N; i++) fr[i] = 100 + 7 * i;
        send_frame();
        for (int i = 0; i < N; i++) fr[i] = -50 - 3 * i;
        send_frame();
        check("ready_full2", s_ready, 1'b0);
        idle();
        drain();
        repeat (10) @(posedge clk);
        #1;

        // 3) short frame
        e0 = err_cnt;
        v0 = vv_cnt;
        for (int i = 0; i < 5; i++) beat(900 + i, i == 4);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("short_err", 32'(err_cnt - e0), 32'd1);
        check("short_no_vv", 32'(vv_cnt - v0), 32'd0);
        for (int i = 0; i < N; i++) fr[i] = 20 * i - 120;
        send_frame();
        idle();
        drain();
        check("clean_no_err", 32'(err_cnt - e0), 32'd1);
        repeat (10) @(posedge clk);
        #1;

        // 4) long frame: error on the 13th beat, 14th dropped
        e0 = err_cnt;
        for (int i = 0; i < N; i++) beat(500 + i, 1'b0);
        check("long_err_at13", frame_err, 1'b1);
        beat(777, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("long_err_count", 32'(err_cnt - e0), 32'd1);
        for (int i = 0; i < N; i++) fr[i] = 1000 - 11 * i;
        send_frame();
        idle();
        drain();
        repeat (10) @(posedge clk);
        #1;

        // 5) conversion extremes plus random values
        fr[0] = 3000;
        fr[1] = -3000;
        for (int i = 2; i < N; i++) fr[i] = int'($urandom_range(8000, 0)) - 4000;
        send_frame();
        idle();
        drain();
`ifdef NN_LOADER_SAT_EN
        check("conv_pos", vec_out[0], 12'h7FF);
        check("conv_neg", vec_out[1], 12'h800);
`else
        check("conv_pos", vec_out[0], 12'hBB8);
        check("conv_neg", vec_out[1], 12'h448);
`endif
        repeat (10) @(posedge clk);
        #1;

        // 6) reset mid-frame, then reset during hold
        for (int i = 0; i < 7; i++) beat(60 + i, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        check("rst_mid_frame", {s_ready, vec_valid, hold_busy, frame_err, vec_out}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < N; i++) fr[i] = 3 * i + 1;
        send_frame();
        idle();
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("busy_before_rst", hold_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_in_hold", {s_ready, vec_valid, hold_busy, frame_err, vec_out}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < N; i++) fr[i] = 2047 - 5 * i;
        send_frame();
        idle();
        drain();
        repeat (12) @(posedge clk);
        #1;

        check("vv_total", 32'(vv_cnt), 32'd8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
